// File: rtl/rom_fetch_unit.sv
// Instruction fetch front end: PC, ROM read issue, return FIFO, redirect, halt on error.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module rom_fetch_unit #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_en,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  rom_error,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_err,
`ifdef FETCH_PERF_EN
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt,
`endif
   output logic                  halted
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {RUN, HALT} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  err;
   } entry_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic                  infl_q, infl_d;
   logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
   entry_t                fifo_q [DEPTH];
   entry_t                fifo_d [DEPTH];

   logic [CW:0] occ;
   logic        issue;
   logic        push;
   logic        pop;
   entry_t      head;

   // Space is judged on registered occupancy plus the outstanding read.
   assign occ   = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
   assign issue = !rst && (state_q == RUN) && !redirect_valid &&
                  (occ < (CW+1)'(DEPTH));
   assign push  = infl_q && !redirect_valid;
   assign pop   = instr_valid && instr_ready && !redirect_valid;
   assign head  = fifo_q[rptr_q];

   assign rom_en      = issue;
   assign rom_addr    = pc_q;
   assign instr_valid = (cnt_q != '0);
   assign instr_data  = instr_valid ? head.data : '0;
   assign instr_pc    = instr_valid ? head.pc : '0;
   assign instr_err   = instr_valid ? head.err : 1'b0;
   assign halted      = (state_q == HALT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      infl_d  = 1'b0;
      iaddr_d = iaddr_q;
      fifo_d  = fifo_q;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         cnt_d   = '0;
         wptr_d  = '0;
         rptr_d  = '0;
         state_d = RUN;
      end else begin
         if (issue) begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            iaddr_d = pc_q;
            infl_d  = 1'b1;
         end
         if (push) begin
            fifo_d[wptr_q] = '{data: rom_data, pc: iaddr_q, err: rom_error};
            wptr_d         = wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
         unique case (state_q)
            RUN:     if (push && rom_error) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         infl_q  <= 1'b0;
         iaddr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         infl_q  <= infl_d;
         iaddr_q <= iaddr_d;
         fifo_q  <= fifo_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating counters; redirect leaves them alone.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (issue && (fetch_cnt_q != '1)) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (instr_valid && !instr_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Randomized scoreboard bench for rom_fetch_unit with an abstract
// occupancy/halt model and a registered ROM model.
module tb_rom_fetch_unit;
   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 2;
   localparam logic [AW-1:0] RST_PC = 8'h00;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] rom_addr;
   logic          rom_en;
   logic [DW-1:0] rom_data = '0;
   logic          rom_error = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b1;
   logic [DW-1:0] instr_data;
   logic [AW-1:0] instr_pc;
   logic          instr_err;
   logic          halted;
`ifdef FETCH_PERF_EN
   logic [31:0]   perf_fetch_cnt;
   logic [31:0]   perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   rom_fetch_unit #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(RST_PC), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .rom_addr(rom_addr), .rom_en(rom_en),
      .rom_data(rom_data), .rom_error(rom_error),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc), .instr_err(instr_err),
`ifdef FETCH_PERF_EN
      .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
      .halted(halted)
   );

   logic [DW-1:0] rom_mem [256];
   bit            rom_bad [256];

   // ROM answers one cycle after a read; garbage otherwise.
   always @(posedge clk) begin
      if (rom_en) begin
         rom_data  <= rom_mem[rom_addr];
         rom_error <= rom_bad[rom_addr];
      end else begin
         rom_data  <= DW'($urandom);
         rom_error <= 1'($urandom_range(0, 1));
      end
   end

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] d;
      logic          e;
   } exp_t;

   exp_t sb [$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, req, $time);
      end
   endtask

   // Model: occ = words held in FIFO plus the outstanding read.
   int            occ  = 0;
   bit            infl = 0;
   bit            errp = 0;
   bit            halt = 0;
   logic [AW-1:0] mpc  = RST_PC;
   int unsigned   fe   = 0;
   int unsigned   st   = 0;

   always @(negedge clk) begin
      bit en_exp, v_exp, pop;
      if (rst) begin
         occ = 0; infl = 0; errp = 0; halt = 0;
         mpc = RST_PC; fe = 0; st = 0;
         sb.delete();
      end else begin
         en_exp = !halt && !redirect_valid && (occ < DEPTH);
         v_exp  = (occ - int'(infl)) > 0;
         chk("rom_en", 32'(rom_en), 32'(en_exp));
         if (en_exp) chk("rom_addr", 32'(rom_addr), 32'(mpc));
         chk("instr_valid", 32'(instr_valid), 32'(v_exp));
         chk("halted", 32'(halted), 32'(halt));
`ifdef FETCH_PERF_EN
         chk("perf_fetch", perf_fetch_cnt, fe);
         chk("perf_stall", perf_stall_cnt, st);
`endif
         if (en_exp) fe++;
         if (v_exp && !instr_ready) st++;
         if (redirect_valid) begin
            occ = 0; infl = 0; errp = 0; halt = 0;
            mpc = redirect_pc;
            sb.delete();
         end else begin
            if (infl && errp) halt = 1;
            pop  = v_exp && instr_ready;
            occ  = occ - int'(pop) + int'(en_exp);
            infl = en_exp;
            errp = en_exp && rom_bad[mpc];
            if (en_exp) begin
               sb.push_back('{pc: mpc, d: rom_mem[mpc], e: rom_bad[mpc]});
               mpc = mpc + 8'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && !redirect_valid && instr_valid && instr_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", 32'(instr_pc), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("instr_pc", 32'(instr_pc), 32'(e.pc));
            chk("instr_data", 32'(instr_data), 32'(e.d));
            chk("instr_err", 32'(instr_err), 32'(e.e));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic [AW-1:0] p);
      redirect_valid = 1'b1;
      redirect_pc    = p;
      step(1);
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom_mem[i] = DW'($urandom);
         rom_bad[i] = 1'b0;
      end
      step(3);
      chk("rst_rom_en", 32'(rom_en), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_data", 32'(instr_data), 0);
      chk("rst_pc", 32'(instr_pc), 0);
      chk("rst_err", 32'(instr_err), 0);
      rst = 1'b0;
      step(8);
      instr_ready = 1'b0;
      step(5);
      instr_ready = 1'b1;
      step(6);
      instr_ready = 1'b0;
      step(1);
      redir(8'h40);
      step(3);
      redir(8'h60);
      instr_ready = 1'b1;
      step(6);
      rom_bad[5] = 1'b1;
      redir(8'h00);
      step(12);
      chk("halt_seen", 32'(halted), 1);
      redir(8'h10);
      step(6);
      rom_bad[5] = 1'b0;
      redir(8'hFE);
      step(6);
      for (int i = 0; i < 256; i++) begin
         rom_bad[i] = ($urandom_range(0, 30) == 0);
      end
      for (int c = 0; c < 3000; c++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 500) == 0) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
         end else if ($urandom_range(0, 40) == 0) begin
            redir(AW'($urandom));
         end else begin
            step(1);
         end
      end
`ifdef FETCH_PERF_EN
      rst = 1'b1;
      step(1);
      chk("perf_fetch_rst", perf_fetch_cnt, 0);
      chk("perf_stall_rst", perf_stall_cnt, 0);
      rst = 1'b0;
`endif
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
